// File: rtl/gs_rref_unload.sv
// gs_rref_unload: reads k reduced rows of l bits from the shared row memory
// in address order, streams them on a valid/ready port and counts the
// non-zero rows as the rank. Reads are credit-limited so backpressure never
// drops data. Optional RREF shape checker is built when RREF_CHECK_EN is
// defined; otherwise rref_err is tied low.
module gs_rref_unload #(
    parameter int unsigned k          = 4,
    parameter int unsigned l          = 4,
    parameter int unsigned READ_DELAY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(k)-1:0]      mem_addr,
    output logic                      mem_rw,
    input  logic [l-1:0]              mem_din,
    output logic [l-1:0]              out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [$clog2(k+1)-1:0]    rank,
    output logic                      rref_err
);

    localparam int unsigned AW = $clog2(k);
    localparam int unsigned CW = $clog2(k + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH) + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t                state, next_state;
    logic [READ_DELAY-1:0] inflight_sr;
    logic [CW-1:0]         issue_cnt, ret_cnt;
    logic [l-1:0]          fifo_data [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [NW-1:0]         fifo_count, inflight, occupancy;
    logic                  issue, capture, pop, head_last, accept_start;

    assign capture      = inflight_sr[READ_DELAY-1];
    assign out_valid    = (fifo_count != '0);
    assign pop          = out_valid & out_ready;
    assign head_last    = fifo_last[rd_ptr];
    assign out_data     = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last     = out_valid & head_last;
    assign busy         = (state == ISSUE) || (state == DRAIN);
    assign done         = (state == FINISH);
    assign mem_rw       = 1'b0;
    assign accept_start = start && (state == IDLE);

    // Credit accounting: buffered rows plus reads still in flight. A row
    // popped this cycle is still counted, so its credit frees next cycle.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < READ_DELAY; i++)
            inflight = inflight + NW'(inflight_sr[i]);
        occupancy = fifo_count + inflight;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and read-issue decision. Completion keys on popping the
    // row tagged last, which implies all rows returned and the FIFO drains.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE:   if (start) next_state = ISSUE;
            ISSUE: begin
                if (occupancy < NW'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (issue_cnt == CW'(k - 1)) next_state = DRAIN;
                end
            end
            DRAIN:  if (pop && head_last) next_state = FINISH;
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address/counter/FIFO pointer datapath and rank accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_sr <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            mem_addr    <= '0;
            rank        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            inflight_sr <= (inflight_sr << 1) | READ_DELAY'(issue);
            if (accept_start) begin
                issue_cnt <= '0;
                ret_cnt   <= '0;
                rank      <= '0;
            end
            if (issue) begin
                mem_addr  <= issue_cnt[AW-1:0];
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (state == FINISH) mem_addr <= '0;
            if (capture) begin
                ret_cnt <= ret_cnt + 1'b1;
                wr_ptr  <= wr_ptr + 1'b1;
                if (mem_din != '0) rank <= rank + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; row k-1 carries the last tag.
    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_data[wr_ptr] <= mem_din;
            fifo_last[wr_ptr] <= (ret_cnt == CW'(k - 1));
        end
    end

`ifdef RREF_CHECK_EN
    localparam int unsigned LW = (l > 1) ? $clog2(l) : 1;

    logic [LW-1:0] lead, prev_lead;
    logic          seen_nz, seen_zero, violation;

    // Leading-one column of the captured row (MSB is column 0) and the
    // echelon-shape violation test against the previous rows.
    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i < l; i++)
            if (mem_din[i]) lead = LW'(l - 1 - i);
        violation = (mem_din != '0) &&
                    (seen_zero || (seen_nz && (lead <= prev_lead)));
    end

    // Sticky error flag and checker history, cleared by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rref_err  <= 1'b0;
            prev_lead <= '0;
            seen_nz   <= 1'b0;
            seen_zero <= 1'b0;
        end else if (accept_start) begin
            rref_err  <= 1'b0;
            prev_lead <= '0;
            seen_nz   <= 1'b0;
            seen_zero <= 1'b0;
        end else if (capture) begin
            if (violation) rref_err <= 1'b1;
            if (mem_din != '0) begin
                seen_nz   <= 1'b1;
                prev_lead <= lead;
            end else begin
                seen_zero <= 1'b1;
            end
        end
    end
`else
    assign rref_err = 1'b0;
`endif

endmodule

// File: tb/tb_gs_rref_unload.sv
// Directed bench for gs_rref_unload (k=4, l=4, READ_DELAY=2, FIFO_DEPTH=4).
module tb_gs_rref_unload;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic [1:0] mem_addr;
    logic       mem_rw;
    logic [3:0] mem_din, out_data;
    logic       busy, done, out_valid, out_last;
    logic [2:0] rank;
    logic       rref_err;

    logic [3:0] mem [4];
    logic [3:0] rd_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Row memory with two cycles from registered address to data.
    always @(posedge clk) rd_q <= mem[mem_addr];
    assign mem_din = rd_q;

    gs_rref_unload #(.k(4), .l(4), .READ_DELAY(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_din(mem_din),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .rank(rank), .rref_err(rref_err)
    );

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic load(input logic [3:0] a, b, c, d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    // Runs one unload; mode 0 ready=1, 1 ready low for 'hold' cycles, 2 random.
    task automatic do_unload(input int mode, input int hold, input bit extra_start,
                             output int nrows, output logic [7:0][3:0] got,
                             output logic [7:0] lasts, output int ndone,
                             output bit timeout);
        int done_cyc;
        done_cyc = -1;
        nrows = 0; ndone = 0; lasts = '0; got = '0;
        start = 1'b1;
        out_ready = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc > hold);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = extra_start && (cyc == 3);
            if (out_valid && out_ready) begin
                if (nrows < 8) begin
                    got[nrows]   = out_data;
                    lasts[nrows] = out_last;
                end
                nrows++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        out_ready = 1'b1;
        timeout = (done_cyc < 0);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        load(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        #12;
        checks++;
        if ({busy, done, mem_addr, mem_rw, out_valid, out_last, out_data, rank, rref_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b addr=%0d rw=%b valid=%b last=%b data=%b rank=%0d err=%b, expected all 0",
                     busy, done, mem_addr, mem_rw, out_valid, out_last, out_data, rank, rref_err);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stream;
        logic [5:0] exp_v, act_v;
        logic [1:0] exp_addr;
        load(4'b1000, 4'b0100, 4'b0011, 4'b0000);
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            exp_addr = (c <= 2) ? 2'd0 : (c <= 5) ? 2'(c - 2) : (c <= 8) ? 2'd3 : 2'd0;
            exp_v = {(c >= 1 && c <= 7), (c == 8), (c >= 4 && c <= 7), (c == 7), 1'b0, 1'b0};
            act_v = {busy, done, out_valid, out_last, mem_rw, 1'b0};
            checks++;
            if (act_v !== exp_v || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL stream_ctl c%0d: got busy/done/valid/last/rw=%b addr=%0d expected %b addr=%0d",
                         c, act_v[5:1], mem_addr, exp_v[5:1], exp_addr);
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (out_data !== mem[c - 4]) begin
                    errors++;
                    $display("FAIL stream_data c%0d: got %b expected %b", c, out_data, mem[c - 4]);
                end
            end
            if (c >= 8) begin
                checks++;
                if (rank !== 3'd3 || rref_err !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_rank c%0d: got rank=%0d err=%b expected rank=3 err=0", c, rank, rref_err);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int nrows, ndone;
        logic [7:0][3:0] got;
        logic [7:0] lasts;
        bit timeout;
        load(4'b1000, 4'b0100, 4'b0011, 4'b0000);
        do_unload(1, 12, 1'b0, nrows, got, lasts, ndone, timeout);
        checks++;
        if (timeout || nrows != 4 || ndone != 1) begin
            errors++;
            $display("FAIL bp_count: got rows=%0d dones=%0d timeout=%b expected rows=4 dones=1 timeout=0", nrows, ndone, timeout);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== mem[i]) begin
                errors++;
                $display("FAIL bp_row%0d: got %b expected %b", i, got[i], mem[i]);
            end
        end
        checks++;
        if (lasts[3:0] !== 4'b1000 || rank !== 3'd3) begin
            errors++;
            $display("FAIL bp_last_rank: got last=%b rank=%0d expected last=1000 rank=3", lasts[3:0], rank);
        end
    endtask

    task automatic test_random;
        int nrows, ndone, exp_rank;
        logic [7:0][3:0] got;
        logic [7:0] lasts;
        bit timeout, bad;
        for (int run = 0; run < 100; run++) begin
            load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            exp_rank = 0;
            for (int i = 0; i < 4; i++) if (mem[i] != 4'd0) exp_rank++;
            do_unload(2, 0, 1'b0, nrows, got, lasts, ndone, timeout);
            bad = timeout || nrows != 4 || ndone != 1 || lasts[3:0] !== 4'b1000;
            for (int i = 0; i < 4; i++) if (got[i] !== mem[i]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL rand%0d_seq: got rows=%0d dones=%0d data=%h last=%b expected rows=4 dones=1 data=%h%h%h%h last=1000",
                         run, nrows, ndone, got[3:0], lasts[3:0], mem[3], mem[2], mem[1], mem[0]);
            end
            checks++;
            if (rank !== 3'(exp_rank)) begin
                errors++;
                $display("FAIL rand%0d_rank: got %0d expected %0d", run, rank, exp_rank);
            end
        end
    endtask

    task automatic test_restart_ignored;
        int nrows, ndone;
        logic [7:0][3:0] got;
        logic [7:0] lasts;
        bit timeout, bad;
        load(4'b1000, 4'b0100, 4'b0011, 4'b0000);
        do_unload(0, 0, 1'b1, nrows, got, lasts, ndone, timeout);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) if (got[i] !== mem[i]) bad = 1'b1;
        checks++;
        if (timeout || nrows != 4 || ndone != 1 || bad || rank !== 3'd3) begin
            errors++;
            $display("FAIL restart_ignored: got rows=%0d dones=%0d data=%h rank=%0d expected rows=4 dones=1 data=0348 rank=3",
                     nrows, ndone, got[3:0], rank);
        end
    endtask

    task automatic test_reset_mid;
        int nrows, ndone;
        logic [7:0][3:0] got;
        logic [7:0] lasts;
        bit timeout, bad;
        load(4'b1000, 4'b0100, 4'b0011, 4'b0000);
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0100) begin
            errors++;
            $display("FAIL mid_row2: got valid=%b data=%b expected valid=1 data=0100", out_valid, out_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_addr, mem_rw, out_valid, out_last, out_data, rank, rref_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b addr=%0d valid=%b last=%b data=%b rank=%0d err=%b expected all 0",
                     busy, done, mem_addr, out_valid, out_last, out_data, rank, rref_err);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_unload(0, 0, 1'b0, nrows, got, lasts, ndone, timeout);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) if (got[i] !== mem[i]) bad = 1'b1;
        checks++;
        if (timeout || nrows != 4 || ndone != 1 || bad || rank !== 3'd3) begin
            errors++;
            $display("FAIL mid_restart: got rows=%0d dones=%0d data=%h rank=%0d expected rows=4 dones=1 data=0348 rank=3",
                     nrows, ndone, got[3:0], rank);
        end
    endtask

    task automatic test_rref;
        int nrows, ndone;
        logic [7:0][3:0] got;
        logic [7:0] lasts;
        bit timeout;
        logic exp_err;
`ifdef RREF_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        load(4'b0100, 4'b1000, 4'b0000, 4'b0000);
        do_unload(0, 0, 1'b0, nrows, got, lasts, ndone, timeout);
        checks++;
        if (timeout || rref_err !== exp_err || rank !== 3'd2) begin
            errors++;
            $display("FAIL rref_order: got err=%b rank=%0d timeout=%b expected err=%b rank=2", rref_err, rank, timeout, exp_err);
        end
        load(4'b1000, 4'b0000, 4'b0010, 4'b0000);
        do_unload(0, 0, 1'b0, nrows, got, lasts, ndone, timeout);
        checks++;
        if (timeout || rref_err !== exp_err || rank !== 3'd2) begin
            errors++;
            $display("FAIL rref_gap: got err=%b rank=%0d timeout=%b expected err=%b rank=2", rref_err, rank, timeout, exp_err);
        end
        load(4'b1000, 4'b0010, 4'b0001, 4'b0000);
        do_unload(0, 0, 1'b0, nrows, got, lasts, ndone, timeout);
        checks++;
        if (timeout || rref_err !== 1'b0 || rank !== 3'd3) begin
            errors++;
            $display("FAIL rref_clear: got err=%b rank=%0d timeout=%b expected err=0 rank=3", rref_err, rank, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_restart_ignored();
        test_reset_mid();
        test_rref();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gs_rref_unload.md
Name: gs_rref_unload

Overview:
- Downstream of the Gaussian-elimination controller.
- After elimination completes, reads the k reduced rows (l bits each) back from the shared row memory, in address order 0..k-1.
- Streams the rows out on a valid/ready interface and computes the rank as the count of non-zero rows.
- Owns the memory read port only while busy.

Parameters:
- k, 4, number of rows in row memory
- l, 4, row width in bits
- READ_DELAY, 2, cycles from registered mem_addr to valid mem_din
- FIFO_DEPTH, 4, output buffer depth in rows (power of two, >= READ_DELAY)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begin unload (driven from elimination done)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final row handshake
- mem_addr  out  CLOG2(k)  row memory read address (registered)
- mem_rw  out  1  memory write enable; always 0 (read only)
- mem_din  in  l  row memory read data
- out_data  out  l  row data
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_last  out  1  high with row k-1
- rank  out  CLOG2(k+1)  non-zero row count; stable after done until next start
- rref_err  out  1  sticky RREF violation flag (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-unload): state IDLE; FIFO emptied; in-flight reads discarded.
  - All outputs 0: busy, done, mem_addr, mem_rw, out_valid, out_last, out_data, rank, rref_err.
- States and transitions:
  - IDLE: on start, go to ISSUE; clear rank, rref_err, issue counter and return counter; busy=1 next cycle. start is ignored in every state except IDLE.
  - ISSUE: present addresses 0..k-1, at most one new address per cycle.
  - DRAIN: entered once address k-1 is issued; waits until all k rows have returned and the FIFO is empty.
  - FINISH: lasts one cycle; done=1, busy=0; then back to IDLE.
- Read timing:
  - An address is issued at clock edge n.
  - The matching mem_din is captured at edge n+READ_DELAY.
  - A READ_DELAY-deep valid shift register tracks in-flight reads.
- Credit rule: a new address issues only if fifo_count + inflight < FIFO_DEPTH. Data is therefore never dropped under backpressure.
  - Count must include the entry being popped in the same cycle: a pop frees a credit only on the next cycle.
- Stall: mem_addr holds its last value; no wrap.
  - After k-1 has issued, mem_addr holds k-1 until IDLE.
  - mem_addr returns to 0 in IDLE.
- FIFO:
  - Simultaneous push and pop on a full FIFO is legal; count stays the same.
  - out_data / out_valid come from the FIFO head. out_data is don't-care when out_valid=0.
  - out_last is a tag stored alongside row k-1.
- Rank:
  - Increments at capture time when mem_din != 0.
  - Saturates impossible by width (max k).
- done is asserted exactly one cycle after the handshake of the out_last row.
- Latency with out_ready held 1: first out_valid at cycle READ_DELAY+2 after start; one row per cycle thereafter; done at cycle k+READ_DELAY+2.

Optional Feature:
- Macro: RREF_CHECK_EN.
- Defined: each captured row is checked.
  - Leading-one position (MSB = column 0) of every non-zero row must be strictly greater than that of the previous non-zero row.
  - No non-zero row may follow a zero row.
  - Any violation sets rref_err on the following cycle; it stays set until the next accepted start or reset.
- Not defined: rref_err is tied 0 and no checker logic is generated.

Test Plan:
- k=4, l=4; memory rows 1000, 0100, 0011, 0000; out_ready=1; pulse start.
  - Rows stream in that order; out_last only on 0000; rank=3; done one cycle after the 4th handshake; mem_rw always 0.
- Same data; out_ready=0 for 12 cycles after start, then 1.
  - mem_addr stalls once FIFO_DEPTH rows are buffered or in flight; no row lost or duplicated; order preserved; rank=3.
- Random out_ready toggling (50%) over 100 unloads of random matrices.
  - Output sequence equals the memory contents; rank equals the non-zero row count every run.
- Pulse start again at cycle 3 of an unload.
  - Ignored; exactly 4 rows and one done pulse.
- Assert rst during the 2nd row transfer.
  - All outputs 0 immediately (asynchronously); a fresh start then unloads all 4 rows from address 0.
- With RREF_CHECK_EN: rows 0100, 1000, 0000, 0000 give rref_err=1, rank=2; rows 1000, 0000, 0010, 0000 give rref_err=1.
  - Without the macro, rref_err stays 0 for both.
